// File: rtl/pipe_pkg.sv
// Shared types for the generic pipeline stage register: handshake state
// encoding and the packed per-stage payload structs carried as opaque vectors.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_t;

    // IF/ID payload: fetched instruction and its PC.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    // ID/EX payload: decoded operands and destination.
    typedef struct packed {
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
    } idex_t;

    // EX/MEM payload: compact address/result plus control (32 bits total).
    typedef struct packed {
        logic [23:0] alu_result;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
    } exmem_t;

    // MEM/WB payload: writeback value and destination.
    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_we;
    } memwb_t;

    // Number of held entries for a given state.
    function automatic logic [1:0] occ_of(input pipe_state_t s);
        case (s)
            PS_ONE:  return 2'd1;
            PS_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with optional one-entry skid
// buffer, synchronous flush (bubble insertion) and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter bit               SKID   = 1'b1,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNTW   = 16
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNTW-1:0]   stall_cnt
);

    pipe_state_t      state, state_n;
    logic [WIDTH-1:0] main, main_n;
    logic [WIDTH-1:0] skid, skid_n;
    logic             in_fire, out_fire;

    assign out_valid = (state != PS_EMPTY);
    assign out_data  = main;
    assign occupancy = occ_of(state);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    generate
        if (SKID) begin : g_skid
            // Registered ready: depends on state only, cutting the stall path.
            assign in_ready = (state != PS_TWO);
        end else begin : g_noskid
            // Single entry: accept when empty or when the held item leaves now.
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    // Next-state and payload steering; flush overrides every transition.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
        state_n = state;
        main_n  = main;
        skid_n  = skid;
        if (flush) begin
            state_n = PS_EMPTY;
            main_n  = BUBBLE;
            skid_n  = BUBBLE;
        end else begin
            case (state)
                PS_EMPTY: begin
                    if (in_fire) begin
                        state_n = PS_ONE;
                        main_n  = in_data;
                    end
                end
                PS_ONE: begin
                    if (in_fire && out_fire) begin
                        main_n = in_data;
                    end else if (in_fire && SKID) begin
                        state_n = PS_TWO;
                        skid_n  = in_data;
                    end else if (out_fire) begin
                        state_n = PS_EMPTY;
                        main_n  = BUBBLE;
                    end
                end
                PS_TWO: begin
                    if (out_fire) begin
                        state_n = PS_ONE;
                        main_n  = skid;
                        skid_n  = BUBBLE;
                    end
                end
                default: begin
                    state_n = PS_EMPTY;
                    main_n  = BUBBLE;
                    skid_n  = BUBBLE;
                end
            endcase
        end
    end

    // State and payload registers.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            // NOTE: payload entries are reset because out_data is visible while empty and must show BUBBLE.
            state <= PS_EMPTY;
            main  <= BUBBLE;
            skid  <= BUBBLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
            state <= state_n;
            main  <= main_n;
            skid  <= skid_n;
        end
    end

    // Saturating count of cycles where a valid output is held off; flush does not clear it.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNTW{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: DUT a (SKID=1, CNTW=4, NOP bubble) and DUT b (SKID=0).
// Stimulus pushes expected payloads into per-DUT queues; monitors pop and
// compare whenever an output transfer is presented.
module tb_pipe_stage_reg;

    localparam logic [31:0] A_BUBBLE = 32'h0000_0013;

    logic clk;
    logic nRst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;
    logic [3:0]  a_stall;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;
    logic [15:0] b_stall;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];

    pipe_stage_reg #(.WIDTH(32), .SKID(1'b1), .BUBBLE(A_BUBBLE), .CNTW(4)) u_a (
        .clk(clk), .nRst(nRst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .flush(a_flush), .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_stage_reg #(.WIDTH(32), .SKID(1'b0), .BUBBLE(32'h0), .CNTW(16)) u_b (
        .clk(clk), .nRst(nRst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .flush(b_flush), .occupancy(b_occ), .stall_cnt(b_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor a: outputs sampled at negedge are what transfers at the next posedge.
    always @(negedge clk) begin
        if (nRst && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_out_unexpected: got %h, expected no transfer (t=%0t)", a_out_data, $time);
            end else begin
                check("a_out_data", a_out_data, qa.pop_front());
            end
        end
    end

    // Monitor b.
    always @(negedge clk) begin
        if (nRst && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_out_unexpected: got %h, expected no transfer (t=%0t)", b_out_data, $time);
            end else begin
                check("b_out_data", b_out_data, qb.pop_front());
            end
        end
    end

    initial begin
        nRst = 1'b0;
        a_in_valid = 1'b1; a_in_data = 32'hDEAD; a_out_ready = 1'b0; a_flush = 1'b0;
        b_in_valid = 1'b0; b_in_data = 32'h0;    b_out_ready = 1'b0; b_flush = 1'b0;

        // Reset held with a valid input pending.
        repeat (3) begin
            @(negedge clk);
            check("rst_out_valid", a_out_valid, 1'b0);
            check("rst_out_data",  a_out_data, A_BUBBLE);
            check("rst_in_ready",  a_in_ready, 1'b1);
            check("rst_occ",       a_occ, 2'd0);
            check("rst_stall",     a_stall, 4'd0);
        end
        cyc();
        nRst = 1'b1;
        a_in_valid = 1'b0;

        // Streaming 1..4 with out_ready high.
        for (int i = 1; i <= 4; i++) begin
            a_in_valid = 1'b1; a_in_data = i; a_out_ready = 1'b1;
            qa.push_back(i);
            @(negedge clk);
            check("stream_in_ready",  a_in_ready, 1'b1);
            check("stream_out_valid", a_out_valid, (i > 1));
            if (i > 1) check("stream_occ", a_occ, 2'd1);
            cyc();
        end
        a_in_valid = 1'b0;
        @(negedge clk);
        check("stream_tail_occ", a_occ, 2'd1);
        cyc();
        @(negedge clk);
        check("stream_empty_valid", a_out_valid, 1'b0);
        check("stream_empty_data",  a_out_data, A_BUBBLE);
        check("stream_stall",       a_stall, 4'd0);
        cyc();

        // Backpressure: A then B with out_ready low.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 32'hA0A0; qa.push_back(32'hA0A0);
        @(negedge clk);
        check("bp1_in_ready", a_in_ready, 1'b1);
        cyc();
        a_in_data = 32'hB0B0; qa.push_back(32'hB0B0);
        @(negedge clk);
        check("bp2_occ",   a_occ, 2'd1);
        check("bp2_stall", a_stall, 4'd0);
        cyc();
        a_in_valid = 1'b0;
        @(negedge clk);
        check("bp3_occ",      a_occ, 2'd2);
        check("bp3_in_ready", a_in_ready, 1'b0);
        check("bp3_stall",    a_stall, 4'd1);
        check("bp3_data",     a_out_data, 32'hA0A0);
        cyc();
        @(negedge clk);
        check("bp4_stall", a_stall, 4'd2);
        cyc();
        a_out_ready = 1'b1;
        @(negedge clk);
        check("bp5_stall",    a_stall, 4'd3);
        check("bp5_in_ready", a_in_ready, 1'b0);
        cyc();
        @(negedge clk);
        check("bp6_in_ready", a_in_ready, 1'b1);
        check("bp6_occ",      a_occ, 2'd1);
        cyc();
        @(negedge clk);
        check("bp7_occ", a_occ, 2'd0);
        cyc();

        // Flush while full; C offered during the flush must never appear.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 32'hA2A2;
        cyc();
        a_in_data = 32'hB2B2;
        cyc();
        a_flush = 1'b1; a_in_data = 32'hC0C0;
        @(negedge clk);
        check("fl_occ_before", a_occ, 2'd2);
        check("fl_stall_before", a_stall, 4'd4);
        cyc();
        a_flush = 1'b0; a_in_valid = 1'b0;
        @(negedge clk);
        check("fl_out_valid", a_out_valid, 1'b0);
        check("fl_occ",       a_occ, 2'd0);
        check("fl_out_data",  a_out_data, A_BUBBLE);
        check("fl_stall",     a_stall, 4'd5);
        cyc();

        // Flush while empty: D is handshaken but discarded.
        a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 32'hD0D0;
        @(negedge clk);
        check("fle_in_ready", a_in_ready, 1'b1);
        cyc();
        a_flush = 1'b0; a_in_valid = 1'b0;
        @(negedge clk);
        check("fle_out_valid", a_out_valid, 1'b0);
        cyc();

        // Flush concurrent with an output transfer: E still delivered.
        a_in_valid = 1'b1; a_in_data = 32'hE0E0; qa.push_back(32'hE0E0);
        cyc();
        a_in_valid = 1'b0; a_flush = 1'b1; a_out_ready = 1'b1;
        cyc();
        a_flush = 1'b0; a_out_ready = 1'b0;
        @(negedge clk);
        check("flo_out_valid", a_out_valid, 1'b0);
        check("flo_stall",     a_stall, 4'd5);
        cyc();

        // Saturation: hold F against out_ready low for 20 cycles.
        a_in_valid = 1'b1; a_in_data = 32'hF0F0;
        cyc();
        for (int k = 0; k < 20; k++) begin
            a_in_valid = 1'b0;
            @(negedge clk);
            check("sat_stall", a_stall, ((5 + k) > 15) ? 32'd15 : 32'(5 + k));
            cyc();
        end
        a_flush = 1'b1;
        @(negedge clk);
        check("sat_stall_end", a_stall, 4'd15);
        cyc();
        a_flush = 1'b0;
        @(negedge clk);
        check("sat_after_flush", a_stall, 4'd15);
        check("sat_flush_valid", a_out_valid, 1'b0);
        cyc();

        // SKID=0: combinational in_ready and pass-through.
        b_in_valid = 1'b1; b_in_data = 32'h11; b_out_ready = 1'b0; qb.push_back(32'h11);
        @(negedge clk);
        check("b1_in_ready", b_in_ready, 1'b1);
        cyc();
        b_in_data = 32'h22;
        @(negedge clk);
        check("b2_in_ready", b_in_ready, 1'b0);
        check("b2_occ",      b_occ, 2'd1);
        cyc();
        b_out_ready = 1'b1; qb.push_back(32'h22);
        @(negedge clk);
        check("b3_in_ready", b_in_ready, 1'b1);
        cyc();
        b_in_data = 32'h33; qb.push_back(32'h33);
        @(negedge clk);
        check("b4_in_ready", b_in_ready, 1'b1);
        check("b4_occ",      b_occ, 2'd1);
        cyc();
        b_in_valid = 1'b0;
        cyc();
        @(negedge clk);
        check("b6_out_valid", b_out_valid, 1'b0);
        check("b6_occ",       b_occ, 2'd0);
        check("b6_stall",     b_stall, 16'd1);
        cyc();

        repeat (2) cyc();
        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
